delay_line_prog: RTL and testbench

- Multi-channel, run-time programmable digital delay line.
- Each 1-bit input channel is delayed by its own cycle count D (1..DEPTH), set through a valid/ready config port.
- Per-channel settle tracking blanks outputs until the history is valid after reset or reprogramming.
- Two status LED outputs: heartbeat and output activity. Parametrised successor of the fixed single-channel delay_line top.

---
 rtl/delay_line_prog_if.sv | 26 ++
 rtl/delay_line_prog.sv | 136 +++++++++++++
 tb/tb_delay_line_prog.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/delay_line_prog_if.sv
// Data and configuration bundle for delay_line_prog: channel inputs/outputs,
// settle flags and the valid/ready configuration request with its error pulse.
interface delay_line_prog_if #(
  parameter int CHANNELS = 2,
  parameter int CHAN_W   = 4,
  parameter int DELAY_W  = 11
);
  logic [CHANNELS-1:0] in;
  logic [CHANNELS-1:0] out;
  logic [CHANNELS-1:0] chan_valid;
  logic                cfg_valid;
  logic                cfg_ready;
  logic [CHAN_W-1:0]   cfg_chan;
  logic [DELAY_W-1:0]  cfg_delay;
  logic                cfg_err;

  modport master (
    output in, cfg_valid, cfg_chan, cfg_delay,
    input  out, chan_valid, cfg_ready, cfg_err
  );

  modport slave (
    input  in, cfg_valid, cfg_chan, cfg_delay,
    output out, chan_valid, cfg_ready, cfg_err
  );
endinterface

// File: rtl/delay_line_prog.sv
// Multi-channel run-time programmable delay line with per-channel settle
// tracking, a valid/ready config port and heartbeat / activity LEDs.
module delay_line_prog #(
  parameter int CHANNELS      = 2,
  parameter int DEPTH         = 64,
  parameter int DELAY_W       = 11,
  parameter int CHAN_W        = 4,
  parameter int DEFAULT_DELAY = 16,
  parameter int HB_DIV        = 25000000,
  parameter int ACT_STRETCH   = 1000000
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  delay_line_prog_if.slave bus,
  output logic             led0,
  output logic             led1
);
  localparam int HB_W  = $clog2(HB_DIV + 1);
  localparam int ACT_W = $clog2(ACT_STRETCH + 1);
  localparam logic [DELAY_W-1:0] DEF_D = DELAY_W'(DEFAULT_DELAY);

  logic                cfg_ready_q;
  logic                cfg_err_q, cfg_err_d;
  logic                cfg_xfer, cfg_ok, cfg_accept;
  logic [CHANNELS-1:0] out_vec, out_next, valid_vec;
  logic [HB_W-1:0]     hb_q, hb_d;
  logic                led0_q, led0_d;
  logic [ACT_W-1:0]    act_q, act_d;

  assign cfg_xfer   = bus.cfg_valid && cfg_ready_q;
  assign cfg_ok     = (int'(bus.cfg_chan) < CHANNELS) &&
                      (int'(bus.cfg_delay) >= 1) &&
                      (int'(bus.cfg_delay) <= DEPTH);
  assign cfg_accept = cfg_xfer && cfg_ok;
  assign cfg_err_d  = cfg_xfer && !cfg_ok;

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
      logic [DEPTH-2:0]   hist_q, hist_d;
      logic [DELAY_W-1:0] delay_q, delay_d, cnt_q, cnt_d;
      logic               valid_q, valid_d, out_q, out_d, tap, hit;

      // History holds DEPTH-1 past samples; D=1 taps the live input directly.
      if (DEPTH > 2) begin : g_long
        assign hist_d = {hist_q[DEPTH-3:0], bus.in[gi]};
      end else begin : g_short
        assign hist_d = bus.in[gi];
      end

      assign hit = cfg_accept && (bus.cfg_chan == CHAN_W'(gi));

      always_comb begin
        tap = bus.in[gi];
        for (int i = 0; i < DEPTH - 1; i++) begin
          if (delay_q == DELAY_W'(i + 2)) tap = hist_q[i];
        end
      end

      // An accepted reconfiguration beats a counter reaching zero.
      always_comb begin
        delay_d = delay_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        if (hit) begin
          delay_d = bus.cfg_delay;
          cnt_d   = bus.cfg_delay;
          valid_d = 1'b0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - DELAY_W'(1);
          if (cnt_q == DELAY_W'(1)) valid_d = 1'b1;
        end
        out_d = valid_d & tap;
      end

      always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
          hist_q  <= '0;
          delay_q <= DEF_D;
          cnt_q   <= DEF_D;
          valid_q <= 1'b0;
          out_q   <= 1'b0;
        end else begin
          hist_q  <= hist_d;
          delay_q <= delay_d;
          cnt_q   <= cnt_d;
          valid_q <= valid_d;
          out_q   <= out_d;
        end
      end

      assign out_vec[gi]   = out_q;
      assign out_next[gi]  = out_d;
      assign valid_vec[gi] = valid_q;
    end
  endgenerate

  // Activity stretch reloads on the same edge an output bit rises.
  always_comb begin
    hb_d   = hb_q + HB_W'(1);
    led0_d = led0_q;
    if (hb_q == HB_W'(HB_DIV - 1)) begin
      hb_d   = '0;
      led0_d = ~led0_q;
    end
    act_d = act_q;
    if ((out_next & ~out_vec) != '0) begin
      act_d = ACT_W'(ACT_STRETCH);
    end else if (act_q != '0) begin
      act_d = act_q - ACT_W'(1);
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cfg_ready_q <= 1'b0;
      cfg_err_q   <= 1'b0;
      hb_q        <= '0;
      led0_q      <= 1'b0;
      act_q       <= '0;
    end else begin
      cfg_ready_q <= 1'b1;
      cfg_err_q   <= cfg_err_d;
      hb_q        <= hb_d;
      led0_q      <= led0_d;
      act_q       <= act_d;
    end
  end

  assign bus.out        = out_vec;
  assign bus.chan_valid = valid_vec;
  assign bus.cfg_ready  = cfg_ready_q;
  assign bus.cfg_err    = cfg_err_q;
  assign led0           = led0_q;
  assign led1           = (act_q != '0);
endmodule

// File: tb/tb_delay_line_prog.sv
// Directed + randomized bench for delay_line_prog against an edge-indexed
// reference model of input history, delays and settle deadlines.
module tb_delay_line_prog;
  localparam int CH   = 2;
  localparam int DEP  = 64;
  localparam int DEFD = 16;
  localparam int HB   = 4;
  localparam int ACT  = 8;
  localparam int HMAX = 8192;

  logic clk;
  logic rst_n;
  logic led0, led1;

  delay_line_prog_if #(.CHANNELS(CH), .CHAN_W(4), .DELAY_W(11)) bus ();

  delay_line_prog #(
    .CHANNELS(CH), .DEPTH(DEP), .DELAY_W(11), .CHAN_W(4),
    .DEFAULT_DELAY(DEFD), .HB_DIV(HB), .ACT_STRETCH(ACT)
  ) dut (
    .clk_in  (clk),
    .rst_n_in(rst_n),
    .bus     (bus.slave),
    .led0    (led0),
    .led1    (led1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  int         k;
  int         d_cur  [CH];
  int         settle [CH];
  logic       in_at  [CH][HMAX];
  logic [1:0] o_exp, v_exp, o_prev;
  logic       err_exp;
  bit         have_rise;
  int         last_rise;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s k=%0d observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  task automatic model_reset();
    k         = 0;
    o_prev    = '0;
    err_exp   = 1'b0;
    have_rise = 1'b0;
    last_rise = 0;
    for (int c = 0; c < CH; c++) begin
      d_cur[c]  = DEFD;
      settle[c] = DEFD;
    end
  endtask

  // One clock edge: apply the model for that edge, then compare every output.
  task automatic cycle();
    logic [1:0] in_s;
    logic       xfer;
    int         ch, dl;
    in_s = bus.in;
    xfer = bus.cfg_valid;
    ch   = int'(bus.cfg_chan);
    dl   = int'(bus.cfg_delay);
    @(posedge clk);
    k++;
    if (k >= HMAX) begin
      $display("FAIL model_index k=%0d exceeds history %0d", k, HMAX);
      $fatal(1);
    end
    err_exp = 1'b0;
    if (xfer && k >= 2) begin
      if (ch < CH && dl >= 1 && dl <= DEP) begin
        d_cur[ch]  = dl;
        settle[ch] = k + dl;
      end else begin
        err_exp = 1'b1;
      end
    end
    for (int c = 0; c < CH; c++) begin
      in_at[c][k] = in_s[c];
      v_exp[c]    = (k >= settle[c]);
      o_exp[c]    = v_exp[c] ? in_at[c][k - d_cur[c] + 1] : 1'b0;
    end
    if ((o_exp & ~o_prev) != 2'b00) begin
      have_rise = 1'b1;
      last_rise = k;
    end
    o_prev = o_exp;
    #1;
    chk("out", 32'(bus.out), 32'(o_exp));
    chk("chan_valid", 32'(bus.chan_valid), 32'(v_exp));
    chk("cfg_ready", 32'(bus.cfg_ready), 32'd1);
    chk("cfg_err", 32'(bus.cfg_err), 32'(err_exp));
    chk("led0", 32'(led0), 32'((k / HB) % 2));
    chk("led1", 32'(led1), 32'(have_rise && (k - last_rise) < ACT));
  endtask

  task automatic cfg(input int ch, input int dl);
    bus.cfg_valid = 1'b1;
    bus.cfg_chan  = 4'(ch);
    bus.cfg_delay = 11'(dl);
    cycle();
    bus.cfg_valid = 1'b0;
    $display("cfg k=%0d ch=%0d d=%0d %s", k, ch, dl, err_exp ? "rejected" : "accepted");
  endtask

  task automatic rand_cycle();
    bus.in = 2'($urandom);
    cycle();
  endtask

  task automatic reset_zero_checks(input string tag);
    chk({tag, "_out"}, 32'(bus.out), 32'd0);
    chk({tag, "_valid"}, 32'(bus.chan_valid), 32'd0);
    chk({tag, "_ready"}, 32'(bus.cfg_ready), 32'd0);
    chk({tag, "_err"}, 32'(bus.cfg_err), 32'd0);
    chk({tag, "_led0"}, 32'(led0), 32'd0);
    chk({tag, "_led1"}, 32'(led1), 32'd0);
  endtask

  initial begin
    rst_n         = 1'b1;
    bus.in        = '0;
    bus.cfg_valid = 1'b0;
    bus.cfg_chan  = '0;
    bus.cfg_delay = '0;

    // Reset state before and during clock edges.
    #2 rst_n = 1'b0;
    #1 reset_zero_checks("reset_t0");
    repeat (2) begin
      @(posedge clk);
      #1 reset_zero_checks("reset_held");
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // Default settle: valid exactly at the 16th edge.
    repeat (DEFD - 1) cycle();
    chk("settle_pre", 32'(bus.chan_valid), 32'd0);
    cycle();
    chk("settle_done", 32'(bus.chan_valid), 32'd3);

    // Single pulse on ch0.
    bus.in = 2'b01;
    cycle();
    bus.in = 2'b00;
    repeat (20) cycle();

    // Reprogram ch1 to 5 and run the 100/10 pattern on it.
    cfg(1, 5);
    for (int t = 0; t < 330; t++) begin
      bus.in[1] = ((t % 110) >= 100);
      bus.in[0] = 1'($urandom);
      cycle();
    end

    // Boundary delays and rejected requests.
    cfg(0, 1);
    repeat (20) rand_cycle();
    cfg(0, DEP);
    repeat (80) rand_cycle();
    cfg(0, 0);
    cycle();
    cfg(1, DEP + 1);
    cfg(2, 7);
    repeat (10) rand_cycle();

    // Collision: reconfigure ch0 on the edge its counter hits zero.
    cfg(0, 10);
    repeat (9) rand_cycle();
    cfg(0, 3);
    chk("collision_hold", 32'(bus.chan_valid[0]), 32'd0);
    repeat (2) rand_cycle();
    chk("collision_wait", 32'(bus.chan_valid[0]), 32'd0);
    rand_cycle();
    chk("collision_rise", 32'(bus.chan_valid[0]), 32'd1);

    // Randomized traffic with random (often invalid) config requests.
    for (int t = 0; t < 500; t++) begin
      bus.in = 2'($urandom);
      if ($urandom_range(0, 11) == 0) begin
        bus.in = 2'($urandom);
        cfg($urandom_range(0, 2), $urandom_range(0, DEP + 2));
      end else begin
        cycle();
      end
    end

    // Activity LED: two output rises five cycles apart.
    cfg(0, 1);
    bus.in = 2'b00;
    repeat (80) cycle();
    bus.in = 2'b01;
    cycle();
    bus.in = 2'b00;
    repeat (4) cycle();
    bus.in = 2'b01;
    cycle();
    bus.in = 2'b00;
    repeat (12) cycle();

    // Asynchronous reset between edges, then default delay again.
    repeat (10) rand_cycle();
    #3 rst_n = 1'b0;
    #1 reset_zero_checks("async_reset");
    @(posedge clk);
    #1 reset_zero_checks("async_held");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (60) rand_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
